// File: rtl/mem_read_a_blocked_if.sv
// Config, handshake and read-port bundle for the blocked A read address generator.
interface mem_read_a_blocked_if #(
    parameter int unsigned N1           = 4,
    parameter int unsigned MATRIXSIZE_W = 16,
    parameter int unsigned ADDR_W       = 12
);
    logic [MATRIXSIZE_W-1:0] M2;
    logic [MATRIXSIZE_W-1:0] M1dN1;
    logic [MATRIXSIZE_W-1:0] BLOCKS;
    logic [MATRIXSIZE_W-1:0] BLOCK_WIDTH;
    logic [MATRIXSIZE_W-1:0] N2TILES;
    logic                    start;
    logic                    stall;
    logic [N1*ADDR_W-1:0]    rd_addr_A;
    logic [N1-1:0]           rd_en_A;
    logic                    busy;
    logic                    done;

    modport master (
        output M2, M1dN1, BLOCKS, BLOCK_WIDTH, N2TILES, start, stall,
        input  rd_addr_A, rd_en_A, busy, done
    );

    modport slave (
        input  M2, M1dN1, BLOCKS, BLOCK_WIDTH, N2TILES, start, stall,
        output rd_addr_A, rd_en_A, busy, done
    );
endinterface

// File: rtl/mem_read_a_blocked.sv
// Walks the N1 blocked A memories (phase, rep, block, col) and issues per-memory
// read addresses/enables with a one-cycle-per-row systolic skew.
module mem_read_a_blocked #(
    parameter int unsigned N1           = 4,
    parameter int unsigned MATRIXSIZE_W = 16,
    parameter int unsigned ADDR_W       = 12
) (
    input logic                clk,
    input logic                rst,
    mem_read_a_blocked_if.slave bus
);
    localparam int unsigned MW         = MATRIXSIZE_W;
    localparam int unsigned DRAIN_W    = $clog2(N1 + 1);
    localparam int unsigned DRAIN_LAST = (N1 > 1) ? N1 - 2 : 0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [MW-1:0] m2;
        logic [MW-1:0] m1dn1;
        logic [MW-1:0] blocks;
        logic [MW-1:0] block_width;
        logic [MW-1:0] n2tiles;
    } cfg_t;

    state_t              state;
    cfg_t                cfg;
    logic [MW-1:0]       phase;
    logic [MW-1:0]       rep;
    logic [MW-1:0]       blk;
    logic [MW-1:0]       col;
    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   block_offset;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0]   chain_addr [N1];
    logic [N1-1:0]       chain_en;
    logic [N1-1:0]       en_q;
    logic                busy_q;
    logic                done_q;

    logic                last_col_c;
    logic                last_blk_c;
    logic                last_rep_c;
    logic                last_phase_c;
    logic                last_issue_c;
    logic                zero_cfg_c;
    logic [ADDR_W-1:0]   row0_addr_c;
    logic [ADDR_W-1:0]   addr_shift_c [N1];
    logic [N1-1:0]       en_shift_c;

    // Loop-nest wrap flags and the next skew-chain contents (head fed by row 0).
    always_comb begin
        last_col_c   = (col   == cfg.block_width - MW'(1));
        last_blk_c   = (blk   == cfg.blocks      - MW'(1));
        last_rep_c   = (rep   == cfg.n2tiles     - MW'(1));
        last_phase_c = (phase == cfg.m1dn1       - MW'(1));
        last_issue_c = last_col_c && last_blk_c && last_rep_c && last_phase_c;
        zero_cfg_c   = (bus.M1dN1 == '0) || (bus.BLOCKS == '0) ||
                       (bus.BLOCK_WIDTH == '0) || (bus.N2TILES == '0);
        row0_addr_c  = ADDR_W'(col) + offset + block_offset;

        addr_shift_c[0] = (state == RUN) ? row0_addr_c : chain_addr[0];
        en_shift_c      = '0;
        en_shift_c[0]   = (state == RUN);
        for (int unsigned r = 1; r < N1; r++) begin
            addr_shift_c[r] = chain_addr[r-1];
            en_shift_c[r]   = chain_en[r-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cfg          <= '0;
            phase        <= '0;
            rep          <= '0;
            blk          <= '0;
            col          <= '0;
            offset       <= '0;
            block_offset <= '0;
            drain_cnt    <= '0;
            for (int unsigned r = 0; r < N1; r++) chain_addr[r] <= '0;
            chain_en     <= '0;
            en_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            busy_q <= (state == RUN) || (state == DRAIN);
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    en_q     <= '0;
                    chain_en <= '0;
                    if (bus.start) begin
                        cfg          <= '{m2: bus.M2, m1dn1: bus.M1dN1, blocks: bus.BLOCKS,
                                          block_width: bus.BLOCK_WIDTH, n2tiles: bus.N2TILES};
                        phase        <= '0;
                        rep          <= '0;
                        blk          <= '0;
                        col          <= '0;
                        offset       <= '0;
                        block_offset <= '0;
                        drain_cnt    <= '0;
                        state        <= zero_cfg_c ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (bus.stall) begin
                        en_q <= '0;
                    end else begin
                        chain_addr <= addr_shift_c;
                        chain_en   <= en_shift_c;
                        en_q       <= en_shift_c;
                        // Innermost col, then block, rep and phase; offset persists across reps.
                        if (last_col_c) begin
                            col <= '0;
                            if (last_blk_c) begin
                                blk          <= '0;
                                block_offset <= '0;
                                if (last_rep_c) begin
                                    rep <= '0;
                                    if (last_phase_c) begin
                                        phase  <= '0;
                                        offset <= '0;
                                    end else begin
                                        phase  <= phase + MW'(1);
                                        offset <= offset + ADDR_W'(cfg.m2);
                                    end
                                end else begin
                                    rep <= rep + MW'(1);
                                end
                            end else begin
                                blk          <= blk + MW'(1);
                                block_offset <= block_offset + ADDR_W'(cfg.block_width);
                            end
                        end else begin
                            col <= col + MW'(1);
                        end
                        if (last_issue_c) state <= (N1 > 1) ? DRAIN : DONE;
                    end
                end
                DRAIN: begin
                    if (bus.stall) begin
                        en_q <= '0;
                    end else begin
                        chain_addr <= addr_shift_c;
                        chain_en   <= en_shift_c;
                        en_q       <= en_shift_c;
                        if (drain_cnt == DRAIN_W'(DRAIN_LAST)) begin
                            drain_cnt <= '0;
                            state     <= DONE;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                end
                DONE: begin
                    en_q     <= '0;
                    chain_en <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < N1; r++) begin : g_addr
        assign bus.rd_addr_A[r*ADDR_W +: ADDR_W] = chain_addr[r];
    end
    assign bus.rd_en_A = en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_mem_read_a_blocked.sv
// Bench for mem_read_a_blocked: issue-list/progress model checked every cycle,
// plus hand-computed literal expectations from the directed scenarios.
module tb_mem_read_a_blocked;
    localparam int unsigned N1 = 4;
    localparam int unsigned MW = 16;
    localparam int unsigned AW = 12;
    localparam int          CAP = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_read_a_blocked_if #(.N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(AW)) bus ();

    mem_read_a_blocked #(.N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model: full row-0 issue list for the latched pass plus a progress count.
    logic [AW-1:0] m_q [$];
    int            m_L;
    int            m_p;
    bit            m_active;
    bit            m_pend;
    logic [AW-1:0] exp_addr [N1];
    logic [N1-1:0] exp_en;
    logic          exp_busy;
    logic          exp_done;

    // Scenario controls and per-cycle captures.
    int rel;
    int start_at [$];
    int stall_lo = -1, stall_hi = -1, rst_at = -1, sw_at = -1;
    int cfg_a [5];
    int cfg_b [5];
    logic [N1*AW-1:0] cap_addr [CAP];
    logic [N1-1:0]    cap_en   [CAP];
    logic             cap_busy [CAP];
    logic             cap_done [CAP];

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    function automatic logic [N1*AW-1:0] pack_exp();
        logic [N1*AW-1:0] v;
        for (int r = 0; r < N1; r++) v[r*AW +: AW] = exp_addr[r];
        return v;
    endfunction

    function automatic logic [AW-1:0] slice(input int i, input int r);
        logic [N1*AW-1:0] v;
        v = cap_addr[i];
        return v[r*AW +: AW];
    endfunction

    task automatic build_issues();
        int m2, m1, nb, bw, n2;
        m2 = int'(bus.M2); m1 = int'(bus.M1dN1); nb = int'(bus.BLOCKS);
        bw = int'(bus.BLOCK_WIDTH); n2 = int'(bus.N2TILES);
        m_q.delete();
        for (int ph = 0; ph < m1; ph++)
            for (int rp = 0; rp < n2; rp++)
                for (int b = 0; b < nb; b++)
                    for (int c = 0; c < bw; c++)
                        m_q.push_back(AW'((ph * m2 + b * bw + c) % (1 << AW)));
        m_L = m_q.size();
    endtask

    // Expected outputs after one clock edge, from the inputs sampled at that edge.
    task automatic model_edge();
        int idx;
        if (rst) begin
            m_active = 1'b0; m_pend = 1'b0; m_p = 0;
            for (int r = 0; r < N1; r++) exp_addr[r] = '0;
            exp_en = '0; exp_busy = 1'b0; exp_done = 1'b0;
            return;
        end
        exp_en = '0; exp_busy = 1'b0; exp_done = 1'b0;
        if (m_pend) begin
            exp_done = 1'b1;
            m_pend   = 1'b0;
        end else if (m_active) begin
            exp_busy = 1'b1;
            if (!bus.stall) begin
                m_p++;
                for (int r = 0; r < N1; r++) begin
                    idx = m_p - 1 - r;
                    if (idx >= 0 && idx < m_L) begin
                        exp_addr[r] = m_q[idx];
                        exp_en[r]   = 1'b1;
                    end
                end
                if (m_p == m_L + N1 - 1) begin
                    m_active = 1'b0;
                    m_pend   = 1'b1;
                end
            end
        end else if (bus.start) begin
            build_issues();
            if (m_L == 0) m_pend = 1'b1;
            else begin m_active = 1'b1; m_p = 0; end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("rd_addr_A", 64'(bus.rd_addr_A), 64'(pack_exp()));
            cmp("rd_en_A",   64'(bus.rd_en_A),   64'(exp_en));
            cmp("busy",      64'(bus.busy),      64'(exp_busy));
            cmp("done",      64'(bus.done),      64'(exp_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (rel >= 0 && rel < CAP) begin
            cap_addr[rel] = bus.rd_addr_A;
            cap_en[rel]   = bus.rd_en_A;
            cap_busy[rel] = bus.busy;
            cap_done[rel] = bus.done;
        end
        rel++;
    endtask

    task automatic drive_cfg(input bit alt);
        int c [5];
        c = alt ? cfg_b : cfg_a;
        bus.M2 = MW'(c[0]); bus.M1dN1 = MW'(c[1]); bus.BLOCKS = MW'(c[2]);
        bus.BLOCK_WIDTH = MW'(c[3]); bus.N2TILES = MW'(c[4]);
    endtask

    task automatic run_scn(input int n);
        bit s;
        rel = 0;
        for (int i = 0; i < n; i++) begin
            s = 1'b0;
            foreach (start_at[k]) if (start_at[k] == i) s = 1'b1;
            bus.start = s;
            bus.stall = (i >= stall_lo && i <= stall_hi);
            rst       = (i == rst_at);
            drive_cfg(sw_at >= 0 && i >= sw_at);
            tick();
        end
        bus.start = 1'b0; bus.stall = 1'b0; rst = 1'b0;
        start_at.delete();
        stall_lo = -1; stall_hi = -1; rst_at = -1; sw_at = -1;
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.stall = 1'b0;
        cfg_a = '{0, 0, 0, 0, 0};
        cfg_b = '{0, 0, 0, 0, 0};
        drive_cfg(1'b0);
        rel = -100;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        cmp("reset_addr", 64'(bus.rd_addr_A), 64'd0);
        cmp("reset_en",   64'(bus.rd_en_A),   64'd0);
        cmp("reset_busy", 64'(bus.busy),      64'd0);
        cmp("reset_done", 64'(bus.done),      64'd0);

        // Basic pass, L=16.
        cfg_a = '{8, 2, 2, 4, 1};
        start_at = '{0};
        run_scn(21);
        cmp("s1_busy_c0",  64'(cap_busy[0]), 64'd0);
        cmp("s1_first",    64'(slice(1, 0)), 64'd0);
        cmp("s1_en_c1",    64'(cap_en[1]),   64'h1);
        cmp("s1_row0_end", 64'(slice(16, 0)), 64'd15);
        cmp("s1_en_c17",   64'(cap_en[17]),  64'he);
        cmp("s1_row3_end", 64'(slice(19, 3)), 64'd15);
        cmp("s1_en_c19",   64'(cap_en[19]),  64'h8);
        cmp("s1_busy_c19", 64'(cap_busy[19]), 64'd1);
        cmp("s1_done_c19", 64'(cap_done[19]), 64'd0);
        cmp("s1_done_c20", 64'(cap_done[20]), 64'd1);
        cmp("s1_busy_c20", 64'(cap_busy[20]), 64'd0);

        // Back-to-back start with N2TILES=2, L=32.
        cfg_a = '{8, 2, 2, 4, 2};
        start_at = '{0};
        run_scn(40);
        cmp("s2_rep1",     64'(slice(9, 0)),  64'd0);
        cmp("s2_phase1",   64'(slice(17, 0)), 64'd8);
        cmp("s2_last",     64'(slice(32, 0)), 64'd15);
        cmp("s2_done_c36", 64'(cap_done[36]), 64'd1);

        // Stall on cycles 6..8; config changed after latch is ignored.
        cfg_a = '{8, 2, 2, 4, 1};
        cfg_b = '{77, 2, 2, 4, 1};
        sw_at = 3;
        stall_lo = 6; stall_hi = 8;
        start_at = '{0};
        run_scn(26);
        cmp("s3_en_c6",    64'(cap_en[6]),    64'd0);
        cmp("s3_en_c8",    64'(cap_en[8]),    64'd0);
        cmp("s3_hold_c6",  64'(slice(6, 0)),  64'd4);
        cmp("s3_resume",   64'(slice(9, 0)),  64'd5);
        cmp("s3_en_c9",    64'(cap_en[9]),    64'hf);
        cmp("s3_phase1",   64'(slice(12, 0)), 64'd8);
        cmp("s3_done_c22", 64'(cap_done[22]), 64'd0);
        cmp("s3_done_c23", 64'(cap_done[23]), 64'd1);

        // Zero BLOCKS, start coincident with done, then a valid start at cycle 2.
        cfg_a = '{8, 2, 0, 4, 1};
        cfg_b = '{8, 2, 2, 4, 1};
        sw_at = 2;
        stall_lo = 1; stall_hi = 1;
        start_at = '{0, 1, 2};
        run_scn(26);
        cmp("s4_done_c1",  64'(cap_done[1]),  64'd1);
        cmp("s4_busy_c1",  64'(cap_busy[1]),  64'd0);
        cmp("s4_en_c1",    64'(cap_en[1]),    64'd0);
        cmp("s4_first",    64'(slice(3, 0)),  64'd0);
        cmp("s4_en_c3",    64'(cap_en[3]),    64'h1);
        cmp("s4_done_c22", 64'(cap_done[22]), 64'd1);

        // Reset mid-run; starts during the run ignored; restart at 8.
        cfg_a = '{8, 2, 2, 4, 1};
        start_at = '{0, 3, 5, 8};
        rst_at = 6;
        run_scn(31);
        cmp("s5_en_c5",    64'(cap_en[5]),    64'hf);
        cmp("s5_addr_c7",  64'(cap_addr[7]),  64'd0);
        cmp("s5_en_c7",    64'(cap_en[7]),    64'd0);
        cmp("s5_busy_c7",  64'(cap_busy[7]),  64'd0);
        cmp("s5_done_c7",  64'(cap_done[7]),  64'd0);
        cmp("s5_restart",  64'(slice(9, 0)),  64'd0);
        cmp("s5_en_c9",    64'(cap_en[9]),    64'h1);
        cmp("s5_next",     64'(slice(10, 0)), 64'd1);
        cmp("s5_done_c28", 64'(cap_done[28]), 64'd1);

        // Address wrap modulo 2^12 in phase 1.
        cfg_a = '{4000, 2, 1, 200, 1};
        start_at = '{0};
        run_scn(406);
        cmp("s6_issue200",   64'(slice(201, 0)), 64'd4000);
        cmp("s6_issue299",   64'(slice(300, 0)), 64'd3);
        cmp("s6_row2_i200",  64'(slice(203, 2)), 64'd4000);
        cmp("s6_done_c404",  64'(cap_done[404]), 64'd1);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
